// File: rtl/i_cache_axi_rd_bridge_if.sv
// I-cache refill request/response and AXI4 read-channel signals for the refill bridge.
// "master" is the bridge's view; "slave" is the view of the cache plus AXI slave around it.
interface i_cache_axi_rd_bridge_if;
    logic        cache_read_ena;
    logic [63:0] cache_addr;
    logic [63:0] cache_or_data;
    logic        cache_in_ok;
    logic        axi_working_ti;
    logic        rd_err;

    logic        axi_ar_valid;
    logic        axi_ar_ready;
    logic [63:0] axi_ar_addr;
    logic [3:0]  axi_ar_id;
    logic [7:0]  axi_ar_len;
    logic [2:0]  axi_ar_size;
    logic [1:0]  axi_ar_burst;

    logic        axi_r_valid;
    logic        axi_r_ready;
    logic [63:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic        axi_r_last;
    logic [3:0]  axi_r_id;

    modport master (
        input  cache_read_ena, cache_addr,
        output cache_or_data, cache_in_ok, axi_working_ti, rd_err,
        output axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
        input  axi_ar_ready,
        input  axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
        output axi_r_ready
    );

    modport slave (
        output cache_read_ena, cache_addr,
        input  cache_or_data, cache_in_ok, axi_working_ti, rd_err,
        input  axi_ar_valid, axi_ar_addr, axi_ar_id, axi_ar_len, axi_ar_size, axi_ar_burst,
        output axi_ar_ready,
        output axi_r_valid, axi_r_data, axi_r_resp, axi_r_last, axi_r_id,
        input  axi_r_ready
    );
endinterface

// File: rtl/i_cache_axi_rd_bridge.sv
// I-cache refill bridge: one single-beat 64-bit AXI4 read per request, result held
// on the cache side for RESP_HOLD cycles.
module i_cache_axi_rd_bridge #(
    parameter logic [3:0] AXI_ID    = 4'b0000,
    parameter int         RESP_HOLD = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    i_cache_axi_rd_bridge_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_DONE} state_t;

    localparam logic [2:0] HOLD_LOAD = 3'(RESP_HOLD - 1);

    state_t      r_state, w_state_next;
    logic [63:0] r_ar_addr, w_ar_addr_next;
    logic [63:0] r_data, w_data_next;
    logic        r_err, w_err_next;
    logic        r_got_beat, w_got_beat_next;
    logic [2:0]  r_hold_cnt, w_hold_cnt_next;
    logic        r_ar_valid, r_r_ready, r_ok, r_busy;
    logic        w_beat_ok;
    logic [2:0]  w_unused_addr_lsb;

    assign w_unused_addr_lsb = bus.cache_addr[2:0];

    // Beats carrying a foreign ID are still handshaken in R, but never treated as ours.
    assign w_beat_ok = bus.axi_r_valid && (bus.axi_r_id == AXI_ID);

    always_comb begin
        w_state_next    = r_state;
        w_ar_addr_next  = r_ar_addr;
        w_data_next     = r_data;
        w_err_next      = r_err;
        w_got_beat_next = r_got_beat;
        w_hold_cnt_next = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.cache_read_ena) begin
                    w_state_next    = ST_AR;
                    w_ar_addr_next  = {bus.cache_addr[63:3], 3'b000};
                    w_got_beat_next = 1'b0;
                end
            end
            ST_AR: begin
                if (bus.axi_ar_ready) begin
                    w_state_next = ST_R;
                end
            end
            ST_R: begin
                if (w_beat_ok) begin
                    // Only the first matching beat is returned; any trailing beats are drained.
                    if (!r_got_beat) begin
                        w_data_next     = bus.axi_r_data;
                        w_err_next      = (bus.axi_r_resp != 2'b00);
                        w_got_beat_next = 1'b1;
                    end
                    if (bus.axi_r_last) begin
                        w_state_next    = ST_DONE;
                        w_hold_cnt_next = HOLD_LOAD;
                    end
                end
            end
            ST_DONE: begin
                if (r_hold_cnt == 3'd0) begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b0;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake/status flags are registered decodes of the next state, so they are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ar_addr  <= 64'd0;
            r_data     <= 64'd0;
            r_err      <= 1'b0;
            r_got_beat <= 1'b0;
            r_hold_cnt <= 3'd0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_ok       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ar_addr  <= w_ar_addr_next;
            r_data     <= w_data_next;
            r_err      <= w_err_next;
            r_got_beat <= w_got_beat_next;
            r_hold_cnt <= w_hold_cnt_next;
            r_ar_valid <= (w_state_next == ST_AR);
            r_r_ready  <= (w_state_next == ST_R);
            r_ok       <= (w_state_next == ST_DONE);
            r_busy     <= (w_state_next != ST_IDLE);
        end
    end

    assign bus.cache_or_data  = r_data;
    assign bus.cache_in_ok    = r_ok;
    assign bus.axi_working_ti = r_busy;
    assign bus.rd_err         = r_err;

    assign bus.axi_ar_valid   = r_ar_valid;
    assign bus.axi_ar_addr    = r_ar_addr;
    assign bus.axi_ar_id      = AXI_ID;
    assign bus.axi_ar_len     = 8'd0;
    assign bus.axi_ar_size    = 3'b011;
    assign bus.axi_ar_burst   = 2'b01;
    assign bus.axi_r_ready    = r_r_ready;
endmodule

// File: tb/tb_i_cache_axi_rd_bridge.sv
// Scoreboard bench for the I-cache refill bridge: directed requests push expected AR
// addresses and responses; independent monitors check the AR handshake and cache response.
module tb_i_cache_axi_rd_bridge;
    logic clk;
    logic rst;

    i_cache_axi_rd_bridge_if bus ();

    i_cache_axi_rd_bridge #(
        .AXI_ID    (4'b0000),
        .RESP_HOLD (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          req_cyc;
        int          lat;
        bit          b2b;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [63:0] ar_q[$];

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    logic [63:0] b_data [4];
    logic [1:0]  b_resp [4];
    logic [3:0]  b_id   [4];
    logic        b_last [4];
    int          nb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_beat(input int i, input logic [63:0] d, input logic [1:0] r,
                            input logic [3:0] id, input logic l);
        b_data[i] = d;
        b_resp[i] = r;
        b_id[i]   = id;
        b_last[i] = l;
    endtask

    task automatic drive_beat(input int i);
        bus.axi_r_valid = 1'b1;
        bus.axi_r_data  = b_data[i];
        bus.axi_r_resp  = b_resp[i];
        bus.axi_r_id    = b_id[i];
        bus.axi_r_last  = b_last[i];
    endtask

    task automatic push_exp(input logic [63:0] exp_addr, input logic [63:0] d, input logic e,
                            input int lat, input bit b2b);
        rsp_t x;
        x.data    = d;
        x.err     = e;
        x.req_cyc = cyc;
        x.lat     = lat;
        x.b2b     = b2b;
        ar_q.push_back(exp_addr);
        rsp_q.push_back(x);
    endtask

    task automatic req(input logic [63:0] addr, input logic [63:0] exp_addr, input logic [63:0] d,
                       input logic e, input int lat, input bit b2b);
        @(posedge clk);
        #1;
        push_exp(exp_addr, d, e, lat, b2b);
        bus.cache_read_ena = 1'b1;
        bus.cache_addr     = addr;
    endtask

    // AXI slave side for one read: optional AR back-pressure, then the nb prepared beats.
    task automatic serve(input logic [63:0] exp_addr, input int ar_wait, input bit keep_ena,
                         input bit early_r);
        int t;
        if (early_r) drive_beat(0);
        bus.axi_ar_ready = (ar_wait == 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.axi_ar_valid && t < 50);
        chk("ar_valid_seen", {63'd0, bus.axi_ar_valid}, 64'd1);
        for (int k = 0; k < ar_wait; k++) begin
            if (k > 0) @(negedge clk);
            chk("ar_hold_valid", {63'd0, bus.axi_ar_valid}, 64'd1);
            chk("ar_hold_addr", bus.axi_ar_addr, exp_addr);
            @(posedge clk);
            #1;
            if (!keep_ena) bus.cache_read_ena = 1'b0;
        end
        if (ar_wait > 0) bus.axi_ar_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.axi_ar_ready = 1'b0;
        if (!keep_ena) bus.cache_read_ena = 1'b0;
        for (int i = 0; i < nb; i++) begin
            drive_beat(i);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!bus.axi_r_ready && t < 50);
            chk("r_ready_seen", {63'd0, bus.axi_r_ready}, 64'd1);
            @(posedge clk);
            #1;
        end
        bus.axi_r_valid = 1'b0;
    endtask

    // AR monitor: every handshake must match the next expected address and fixed burst fields.
    initial forever begin
        logic [63:0] ea;
        @(negedge clk);
        if (!rst && bus.axi_ar_valid && bus.axi_ar_ready) begin
            chk("ar_expected", {63'd0, ar_q.size() != 0}, 64'd1);
            if (ar_q.size() != 0) begin
                ea = ar_q.pop_front();
                chk("ar_addr", bus.axi_ar_addr, ea);
                chk("ar_len", {56'd0, bus.axi_ar_len}, 64'd0);
                chk("ar_size", {61'd0, bus.axi_ar_size}, 64'd3);
                chk("ar_burst", {62'd0, bus.axi_ar_burst}, 64'd1);
                chk("ar_id", {60'd0, bus.axi_ar_id}, 64'd0);
            end
        end
    end

    // Response monitor: data/err on ok rise, stability and busy while held, hold length on fall.
    initial begin
        rsp_t cur;
        bit   have;
        bit   prev_ok;
        bit   b2b_pending;
        int   run;
        have = 0; prev_ok = 0; b2b_pending = 0; run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ok = 0; have = 0; run = 0; b2b_pending = 0;
            end else if (bus.cache_in_ok) begin
                if (!prev_ok) begin
                    run = 0;
                    chk("rsp_expected", {63'd0, rsp_q.size() != 0}, 64'd1);
                    if (rsp_q.size() != 0) begin
                        cur  = rsp_q.pop_front();
                        have = 1;
                        $display("txn: data=0x%h rd_err=%0d cycle=%0d", bus.cache_or_data, bus.rd_err, cyc);
                        chk("rsp_err", {63'd0, bus.rd_err}, {63'd0, cur.err});
                        if (cur.lat >= 0) chk("rsp_latency", 64'(cyc - cur.req_cyc), 64'(cur.lat));
                    end
                end
                run++;
                if (have) chk("rsp_data", bus.cache_or_data, cur.data);
                chk("busy_during_ok", {63'd0, bus.axi_working_ti}, 64'd1);
            end else if (prev_ok) begin
                chk("ok_hold_cycles", 64'(run), 64'd3);
                chk("busy_drops_with_ok", {63'd0, bus.axi_working_ti}, 64'd0);
                chk("err_drops_with_ok", {63'd0, bus.rd_err}, 64'd0);
                b2b_pending = have && cur.b2b;
                have = 0;
            end else if (b2b_pending) begin
                chk("b2b_busy_back", {63'd0, bus.axi_working_ti}, 64'd1);
                b2b_pending = 0;
            end
            prev_ok = bus.cache_in_ok;
        end
    end

    initial begin
        rst = 1'b1;
        bus.cache_read_ena = 1'b0;
        bus.cache_addr     = 64'd0;
        bus.axi_ar_ready   = 1'b0;
        bus.axi_r_valid    = 1'b0;
        bus.axi_r_data     = 64'd0;
        bus.axi_r_resp     = 2'b00;
        bus.axi_r_last     = 1'b0;
        bus.axi_r_id       = 4'd0;
        nb = 1;
        repeat (3) @(negedge clk);
        chk("rst_data", bus.cache_or_data, 64'd0);
        chk("rst_ok", {63'd0, bus.cache_in_ok}, 64'd0);
        chk("rst_busy", {63'd0, bus.axi_working_ti}, 64'd0);
        chk("rst_err", {63'd0, bus.rd_err}, 64'd0);
        chk("rst_ar_valid", {63'd0, bus.axi_ar_valid}, 64'd0);
        chk("rst_ar_addr", bus.axi_ar_addr, 64'd0);
        chk("rst_r_ready", {63'd0, bus.axi_r_ready}, 64'd0);
        chk("rst_ar_size", {61'd0, bus.axi_ar_size}, 64'd3);
        chk("rst_ar_burst", {62'd0, bus.axi_ar_burst}, 64'd1);
        rst = 1'b0;

        // Basic refill, all handshakes immediate.
        nb = 1;
        set_beat(0, 64'hDEAD_BEEF_0123_4567, 2'b00, 4'h0, 1'b1);
        req(64'h0000_0000_8000_0104, 64'h0000_0000_8000_0100, 64'hDEAD_BEEF_0123_4567, 1'b0, 3, 0);
        serve(64'h0000_0000_8000_0100, 0, 0, 0);
        repeat (6) @(posedge clk);

        // AR ready withheld 5 cycles, request dropped early.
        set_beat(0, 64'hCAFE_F00D_0000_0002, 2'b00, 4'h0, 1'b1);
        req(64'h0000_0000_1234_567F, 64'h0000_0000_1234_5678, 64'hCAFE_F00D_0000_0002, 1'b0, -1, 0);
        serve(64'h0000_0000_1234_5678, 5, 0, 0);
        repeat (6) @(posedge clk);

        // Foreign-ID beat (with last) ignored, then the real beat.
        nb = 2;
        set_beat(0, 64'h3333_3333_3333_3333, 2'b00, 4'h3, 1'b1);
        set_beat(1, 64'h0000_0000_0000_1111, 2'b00, 4'h0, 1'b1);
        req(64'h0000_0000_0000_0040, 64'h0000_0000_0000_0040, 64'h0000_0000_0000_1111, 1'b0, 4, 0);
        serve(64'h0000_0000_0000_0040, 0, 0, 0);
        repeat (6) @(posedge clk);

        // Error on first of two beats: first data kept, err set, DONE only after last.
        set_beat(0, 64'hA5A5_A5A5_5A5A_5A5A, 2'b10, 4'h0, 1'b0);
        set_beat(1, 64'hFFFF_0000_FFFF_0000, 2'b00, 4'h0, 1'b1);
        req(64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF8, 64'hA5A5_A5A5_5A5A_5A5A, 1'b1, 4, 0);
        serve(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0);
        repeat (6) @(posedge clk);

        // R beat already valid during the AR handshake cycle.
        nb = 1;
        set_beat(0, 64'h0BAD_F00D_1357_9BDF, 2'b11, 4'h0, 1'b1);
        req(64'h0000_0001_0000_0009, 64'h0000_0001_0000_0008, 64'h0BAD_F00D_1357_9BDF, 1'b1, 3, 0);
        serve(64'h0000_0001_0000_0008, 0, 0, 1);
        repeat (6) @(posedge clk);

        // Asynchronous reset while waiting in R.
        @(posedge clk);
        #1;
        ar_q.push_back(64'h0000_0000_9000_0040);
        bus.cache_addr     = 64'h0000_0000_9000_0044;
        bus.cache_read_ena = 1'b1;
        bus.axi_ar_ready   = 1'b1;
        @(posedge clk);
        #1;
        bus.cache_read_ena = 1'b0;
        @(posedge clk);
        #1;
        bus.axi_ar_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_r_ready", {63'd0, bus.axi_r_ready}, 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_r_ready", {63'd0, bus.axi_r_ready}, 64'd0);
        chk("arst_busy", {63'd0, bus.axi_working_ti}, 64'd0);
        chk("arst_data", bus.cache_or_data, 64'd0);
        chk("arst_ar_addr", bus.axi_ar_addr, 64'd0);
        chk("arst_ar_valid", {63'd0, bus.axi_ar_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        set_beat(0, 64'h7777_8888_9999_AAAA, 2'b00, 4'h0, 1'b1);
        req(64'h0000_0000_9000_0044, 64'h0000_0000_9000_0040, 64'h7777_8888_9999_AAAA, 1'b0, 3, 0);
        serve(64'h0000_0000_9000_0040, 0, 0, 0);
        repeat (6) @(posedge clk);

        // Request held high: two refills separated by exactly one IDLE cycle.
        set_beat(0, 64'h1111_2222_3333_4444, 2'b00, 4'h0, 1'b1);
        req(64'h0000_0000_2000_0007, 64'h0000_0000_2000_0000, 64'h1111_2222_3333_4444, 1'b0, 3, 1);
        push_exp(64'h0000_0000_2000_0010, 64'h5555_6666_7777_8888, 1'b0, -1, 0);
        serve(64'h0000_0000_2000_0000, 0, 1, 0);
        bus.cache_addr = 64'h0000_0000_2000_0013;
        set_beat(0, 64'h5555_6666_7777_8888, 2'b00, 4'h0, 1'b1);
        serve(64'h0000_0000_2000_0010, 0, 0, 0);
        repeat (8) @(posedge clk);

        chk("ar_queue_drained", 64'(ar_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/i_cache_axi_rd_bridge.md
Name: i_cache_axi_rd_bridge

Overview:
- Responder end of the instruction-cache refill interface.
- Accepts a refill request (`cache_read_ena` / `cache_addr`) from the I-cache and performs one 64-bit AXI4 read (AR + R channels).
- Returns the beat on `cache_or_data` with `cache_in_ok`, and drives the `axi_working_ti` busy flag back to the cache.
- Sits between the I-cache and the AXI interconnect/arbiter.

Parameters:
- AXI_ID, 4'b0000, value driven on `axi_ar_id`; R beats with any other ID are ignored.
- RESP_HOLD, 3, cycles `cache_in_ok` and `cache_or_data` stay asserted/stable in DONE (range 1..7).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cache_read_ena  in  1  refill request level from the I-cache.
- cache_addr  in  64  refill address.
- cache_or_data  out  64  returned read data.
- cache_in_ok  out  1  data-valid to the I-cache.
- axi_working_ti  out  1  bridge busy (request accepted, not yet back in IDLE).
- rd_err  out  1  RRESP of the captured beat was non-OKAY; valid while `cache_in_ok`=1.
- axi_ar_valid  out  1  AR valid.
- axi_ar_ready  in  1  AR ready.
- axi_ar_addr  out  64  AR address.
- axi_ar_id  out  4  AR ID.
- axi_ar_len  out  8  AR burst length.
- axi_ar_size  out  3  AR transfer size.
- axi_ar_burst  out  2  AR burst type.
- axi_r_valid  in  1  R valid.
- axi_r_ready  out  1  R ready.
- axi_r_data  in  64  R data.
- axi_r_resp  in  2  R response.
- axi_r_last  in  1  R last.
- axi_r_id  in  4  R ID.

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - All outputs 0: data, ok, busy, err, ar_valid, ar_addr, r_ready, hold counter.
  - Constant outputs are unaffected: `axi_ar_id`=AXI_ID, `axi_ar_len`=0, `axi_ar_size`=3'b011, `axi_ar_burst`=2'b01.
  - Reset mid-transaction abandons it; the bench does not check AXI rules across reset.
- Address latch:
  - In IDLE with `cache_read_ena`=1, latch `{cache_addr[63:3],3'b000}` and go to AR.
  - `axi_working_ti` = (state != IDLE), registered, so it rises on the cycle after acceptance.
- AR state:
  - `axi_ar_valid`=1 with the latched address.
  - Address and valid are held stable until `axi_ar_ready`; on the handshake edge go to R and drop `axi_ar_valid`.
  - `cache_read_ena` is not sampled outside IDLE; dropping it mid-flight does not cancel the read.
- R state:
  - `axi_r_ready`=1.
  - On `axi_r_valid` && `axi_r_id`==AXI_ID:
    - First such beat: capture data into `cache_or_data` and `rd_err`=(`axi_r_resp`!=2'b00).
    - Later beats are consumed and discarded.
  - When the accepted beat has `axi_r_last`=1, go to DONE and drop `axi_r_ready`.
  - A beat with a mismatched ID is ignored: not accepted as data, but handshaken.
- DONE state:
  - `cache_in_ok`=1 for exactly RESP_HOLD consecutive cycles; data and `rd_err` stay stable.
  - The hold counter is 3 bits, loaded with RESP_HOLD-1 on DONE entry and decremented each cycle.
  - At count 0 go to IDLE; `cache_in_ok`, `rd_err` and busy clear on that edge.
  - `cache_or_data` keeps its last value in IDLE.
- IDLE after DONE:
  - There is a minimum one-cycle gap in IDLE before a new request can be accepted.
  - If `cache_read_ena`=1 in that IDLE cycle, a new read starts (back-to-back refills are allowed).
- Minimum latency, all handshakes immediate: request cycle N → AR valid N+1 → R N+2 → `cache_in_ok` first asserted N+3.
- Simultaneous events:
  - `axi_ar_ready` and `axi_r_valid` in the same AR cycle: the R beat is not taken (r_ready=0); it is taken in R.
  - `axi_r_valid` with a 0-cycle gap after the AR handshake is accepted on the first R cycle.
- Illegal state encodings return to IDLE.

Test Plan:
- `cache_read_ena`=1, `cache_addr`=0x8000_0104, slave ready immediately, R data 0xDEAD_BEEF_0123_4567 resp=0 last=1 → `axi_ar_addr`=0x8000_0100, len=0, size=3; `cache_in_ok` high 3 cycles with that data; `rd_err`=0; busy falls with ok; first ok 3 cycles after request.
- `axi_ar_ready` withheld 5 cycles, request dropped after cycle 1 → `axi_ar_valid` and addr stay stable for all 5 cycles; the read still completes.
- R beat with id=4'h3 then id=0 data 0x1111 last=1 → only 0x1111 is returned.
- Beats resp=2'b10 last=0, then resp=0 last=1 → data from the first beat; `rd_err`=1 during ok; DONE entered only after the last beat.
- Assert rst during R state → all outputs 0 immediately (async); a fresh request afterwards completes normally.
- `cache_read_ena` held high continuously → two full transactions separated by one IDLE cycle; busy low exactly that one cycle.
